// File: rtl/dmem_responder.sv
// Data-memory responder for the core: word RAM plus an MMIO window
// with a console byte FIFO, its status register and a cycle counter.
module dmem_responder #(
    parameter int RAM_AWIDTH = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data_w,
    input  logic        d_data_we,
    output logic [31:0] d_data_r,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RAM_WORDS = 1 << RAM_AWIDTH;

    logic [31:0]           ram [RAM_WORDS];
    logic [31:0]           ram_q;
    logic [7:0]            fifo [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [31:0]           cycles;
    logic [31:0]           mmio_q;
    logic                  use_mmio_q;

    logic                  is_mmio;
    logic                  sel_con;
    logic                  sel_stat;
    logic                  sel_cyc;
    logic [RAM_AWIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  ov_set;
    logic                  ov_clr;
    logic [3:0]            cnt4;
    logic [31:0]           status;
    logic [31:0]           mmio_rdata;

    assign is_mmio  = d_addr[31:16] == 16'hFFFF;
    assign sel_con  = is_mmio && d_addr[15:0] == 16'h0000;
    assign sel_stat = is_mmio && d_addr[15:0] == 16'h0004;
    assign sel_cyc  = is_mmio && d_addr[15:0] == 16'h0008;
    assign ram_idx  = d_addr[RAM_AWIDTH+1:2];
    assign ram_we   = d_data_we && !is_mmio && !reset;

    assign full      = count == CW'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign con_valid = !empty;
    assign con_data  = fifo[rd_ptr];

    // A full FIFO still takes a byte when the sink drains one this cycle.
    assign pop    = con_valid && con_ready;
    assign push   = d_data_we && sel_con && !reset;
    assign accept = push && (!full || pop);
    assign ov_set = push && !accept;
    assign ov_clr = d_data_we && sel_stat && d_data_w[2];

    assign cnt4   = 4'(count);
    assign status = {24'b0, cnt4, 1'b0, overflow, full, empty};

    always_comb begin
        mmio_rdata = '0;
        unique case (1'b1)
            sel_stat: mmio_rdata = status;
            sel_cyc:  mmio_rdata = cycles;
            default:  mmio_rdata = '0;
        endcase
    end

    // Read-first RAM without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= d_data_w;
        end
        ram_q <= ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo[wr_ptr] <= d_data_w[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            cycles     <= '0;
            mmio_q     <= '0;
            use_mmio_q <= 1'b1;
        end else begin
            use_mmio_q <= is_mmio;
            mmio_q     <= mmio_rdata;
            if (d_data_we && sel_cyc) begin
                cycles <= d_data_w;
            end else begin
                cycles <= cycles + 32'd1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (!accept && pop) begin
                count <= count - CW'(1);
            end
            if (ov_set) begin
                overflow <= 1'b1;
            end else if (ov_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign d_data_r = use_mmio_q ? mmio_q : ram_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios then random
// traffic, checked against a queue/array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_data_w;
    logic        d_data_we;
    logic [31:0] d_data_r;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .d_addr    (d_addr),
        .d_data_w  (d_data_w),
        .d_data_we (d_data_we),
        .d_data_r  (d_data_r),
        .con_data  (con_data),
        .con_valid (con_valid),
        .con_ready (con_ready)
    );

    typedef struct {
        bit          chk;
        logic [31:0] dr;
        bit          cv;
        logic [7:0]  cd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo[$];
    bit          m_ov;
    logic [31:0] m_cyc;
    int          checks = 0;
    int          failures = 0;

    // One bus cycle: drive inputs, advance the model, queue the response.
    task automatic step(input logic [31:0] a, input logic [31:0] wd,
                        input bit we, input bit rdy, input bit rst);
        exp_t e;
        bit   pop_m;
        bit   push_m;
        bit   acc_m;
        int   idx;
        reset     = rst;
        d_addr    = a;
        d_data_w  = wd;
        d_data_we = we;
        con_ready = rdy;
        e.chk = 1'b1;
        e.dr  = 32'h0;
        if (rst) begin
            m_fifo.delete();
            m_ov  = 1'b0;
            m_cyc = 32'h0;
        end else begin
            if (a[31:16] != 16'hFFFF) begin
                idx = int'(a[13:2]);
                if (m_ram.exists(idx)) e.dr = m_ram[idx];
                else e.chk = 1'b0;
                if (we) m_ram[idx] = wd;
            end else begin
                case (a)
                    32'hFFFF0004: e.dr = {24'b0, 4'(m_fifo.size()), 1'b0, m_ov,
                                          m_fifo.size() == 8, m_fifo.size() == 0};
                    32'hFFFF0008: e.dr = m_cyc;
                    default:      e.dr = 32'h0;
                endcase
            end
            m_cyc  = (we && a == 32'hFFFF0008) ? wd : m_cyc + 32'd1;
            pop_m  = m_fifo.size() > 0 && rdy;
            push_m = we && a == 32'hFFFF0000;
            acc_m  = push_m && (m_fifo.size() < 8 || pop_m);
            if (we && a == 32'hFFFF0004 && wd[2]) m_ov = 1'b0;
            if (push_m && !acc_m) m_ov = 1'b1;
            if (pop_m) void'(m_fifo.pop_front());
            if (acc_m) m_fifo.push_back(wd[7:0]);
        end
        e.cv = m_fifo.size() > 0;
        e.cd = e.cv ? m_fifo[0] : 8'h00;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
                checks++;
                if (d_data_r !== mon_e.dr) begin
                    failures++;
                    $display("FAIL d_data_r t=%0t got=%h exp=%h", $time, d_data_r, mon_e.dr);
                end
            end
            checks++;
            if (con_valid !== mon_e.cv) begin
                failures++;
                $display("FAIL con_valid t=%0t got=%b exp=%b", $time, con_valid, mon_e.cv);
            end
            if (mon_e.cv) begin
                checks++;
                if (con_data !== mon_e.cd) begin
                    failures++;
                    $display("FAIL con_data t=%0t got=%h exp=%h", $time, con_data, mon_e.cd);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          k;
        step(32'h10, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b1);
        step(32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h40, 32'h12345678, 1'b1, 1'b0, 1'b0);
        step(32'h40, 32'h0BADF00D, 1'b1, 1'b1, 1'b1);
        step(32'hFFFF0008, 32'h55555555, 1'b1, 1'b0, 1'b1);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        // RAM alias and read-first behaviour.
        step(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        step(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h4010, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h20, 32'h11111111, 1'b1, 1'b0, 1'b0);
        step(32'h20, 32'h22222222, 1'b1, 1'b0, 1'b0);
        step(32'h23, 32'h0, 1'b0, 1'b0, 1'b0);
        // Overflow with a stalled sink, then drain.
        for (int i = 0; i < 9; i++) step(32'hFFFF0000, 32'h41 + i, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
        step(32'hFFFF0004, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF0004, 32'h4, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 1'b0);
        // Push into a full FIFO while it drains.
        for (int i = 0; i < 8; i++) step(32'hFFFF0000, 32'h30 + i, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF0000, 32'h5A, 1'b1, 1'b1, 1'b0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(32'hFFFF0004, 32'h0, 1'b0, 1'b1, 1'b0);
        // Counter load and wrap.
        step(32'hFFFF0008, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF000C, 32'h77, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF000C, 32'h0, 1'b0, 1'b0, 1'b0);
        // Reset with bytes queued and overflow set.
        for (int i = 0; i < 9; i++) step(32'hFFFF0000, 32'h61 + i, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(32'h10, 32'h0, 1'b0, 1'b1, 1'b0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF0000, 32'h99, 1'b1, 1'b1, 1'b1);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            k  = $urandom_range(0, 9);
            wd = $urandom;
            a  = $urandom;
            if (k <= 3) begin
                a[13:2] = 12'($urandom_range(0, 15));
                if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
            end else if (k <= 5) begin
                a = 32'hFFFF0000;
            end else if (k == 6) begin
                a = 32'hFFFF0004;
            end else if (k <= 8) begin
                a = 32'hFFFF0008;
            end else begin
                a[31:16] = 16'hFFFF;
                if (a[15:0] < 16'h000C) a[15:0] = 16'h0010;
            end
            step(a, wd, k == 8 ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
